wb_stage: RTL

- Final (writeback) stage of the 5-stage pipeline.
- Consumes the MEM pipeline latch and commits results to the architectural register file.
- Provides DE with register-file reads (with same-cycle write bypass) and the WB-stage forwarding/hazard view.
- Counts retired instructions and halts the core on a halt instruction.

---
 rtl/wb_stage.sv | 94 +++++++++
 1 files changed

// File: rtl/wb_stage.sv
// Writeback stage: commits MEM results to the register file, bypasses same-cycle writes to DE,
// counts retirements and halts the core. Optional cycle counter: WB_PERF_CYCLES_EN.
module wb_stage #(
  parameter int DBITS    = 32,
  parameter int NUM_REGS = 32,
  parameter int REGBITS  = 5
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_in_valid,
  input  logic [DBITS-1:0]   i_in_pc,
  input  logic               i_in_wr_reg,
  input  logic [REGBITS-1:0] i_in_reg_dest,
  input  logic [DBITS-1:0]   i_in_result,
  input  logic               i_in_halt,
  input  logic [REGBITS-1:0] i_rs1_addr,
  input  logic [REGBITS-1:0] i_rs2_addr,
  output logic [DBITS-1:0]   o_rs1_data,
  output logic [DBITS-1:0]   o_rs2_data,
  output logic               o_fwd_wr,
  output logic [REGBITS-1:0] o_fwd_dest,
  output logic [DBITS-1:0]   o_fwd_data,
  output logic [DBITS-1:0]   o_retired_cnt,
  output logic [DBITS-1:0]   o_last_pc,
  output logic               o_halted,
  output logic [DBITS-1:0]   o_perf_cycles
);

  typedef enum logic {RUN = 1'b0, HALTED = 1'b1} state_t;

  state_t           r_state, w_state_nxt;
  logic             w_ret, w_we;
  logic [DBITS-1:0] r_regs [NUM_REGS];
  logic [DBITS-1:0] r_retired, r_last_pc;

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) r_state <= RUN;
    else          r_state <= w_state_nxt;

  always_comb begin
    w_state_nxt = r_state;
    if (r_state == RUN && i_in_valid && i_in_halt) w_state_nxt = HALTED;
  end

  always_comb begin
    w_ret    = i_in_valid & (r_state == RUN);
    w_we     = w_ret & i_in_wr_reg & ~i_in_halt & (i_in_reg_dest != '0);
    o_halted = (r_state == HALTED);
  end

  // x0 is never a write target (w_we excludes it), so its entry holds the reset zero
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_we) begin
      r_regs[i_in_reg_dest] <= i_in_result;
    end

  always_comb begin
    o_rs1_data = r_regs[i_rs1_addr];
    if (i_rs1_addr == '0)                       o_rs1_data = '0;
    else if (w_we && i_rs1_addr == i_in_reg_dest) o_rs1_data = i_in_result;
    o_rs2_data = r_regs[i_rs2_addr];
    if (i_rs2_addr == '0)                       o_rs2_data = '0;
    else if (w_we && i_rs2_addr == i_in_reg_dest) o_rs2_data = i_in_result;
  end

  assign o_fwd_wr   = w_we;
  assign o_fwd_dest = i_in_reg_dest;
  assign o_fwd_data = i_in_result;

  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset) begin
      r_retired <= '0;
      r_last_pc <= '0;
    end else if (w_ret) begin
      r_last_pc <= i_in_pc;
      if (r_retired != '1) r_retired <= r_retired + 1'b1;
    end

  assign o_retired_cnt = r_retired;
  assign o_last_pc     = r_last_pc;

`ifdef WB_PERF_CYCLES_EN
  logic [DBITS-1:0] r_perf;
  always_ff @(posedge i_clk or negedge i_reset)
    if (!i_reset)                           r_perf <= '0;
    else if (r_state == RUN && r_perf != '1) r_perf <= r_perf + 1'b1;
  assign o_perf_cycles = r_perf;
`else
  assign o_perf_cycles = '0;
`endif

endmodule
